board_input_conditioner: RTL and testbench

Input-side front end for the board's buttons and slide switches: it synchronizes every raw pin into the clock domain and debounces each bit independently. It then presents clean levels plus single-cycle press, release and change pulses, and keeps a running count of button presses. It sits between the board I/O pins and the LED/display logic, which consume only its conditioned outputs and never the raw pins.

---
 rtl/board_io_pkg.sv | 8 +
 rtl/board_input_conditioner_if.sv | 25 ++
 rtl/debounce_bit.sv | 47 ++++
 rtl/board_input_conditioner.sv | 42 ++++
 tb/tb_board_input_conditioner.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/board_io_pkg.sv
// board_io_pkg: shared defaults and widths for the board input front end.
package board_io_pkg;
    localparam int DEF_N_BTN           = 5;
    localparam int DEF_N_SW            = 8;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int PRESS_CNT_W         = 16;
    typedef logic [PRESS_CNT_W-1:0] press_cnt_t;
endpackage

// File: rtl/board_input_conditioner_if.sv
// board_input_conditioner_if: raw pins towards the conditioner, clean levels,
// pulses and the press counter back to the consumers.
interface board_input_conditioner_if
    import board_io_pkg::*;
#(
    parameter int N_BTN = DEF_N_BTN,
    parameter int N_SW  = DEF_N_SW
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_SW-1:0]  sw_raw;
    logic [N_SW-1:0]  sw_level;
    logic [N_SW-1:0]  sw_change;
    press_cnt_t       press_cnt;
    modport master (
        output btn_raw, sw_raw,
        input  btn_level, btn_press, btn_release, sw_level, sw_change, press_cnt
    );
    modport slave (
        input  btn_raw, sw_raw,
        output btn_level, btn_press, btn_release, sw_level, sw_change, press_cnt
    );
endinterface

// File: rtl/debounce_bit.sv
// debounce_bit: one pin's synchronizer plus hold-time qualifier, producing the
// accepted level and one-cycle rise/fall pulses.
module debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d, fall_q, fall_d;
    logic                   sync, accept;
    // any return to the accepted value wipes the run, so only a full hold wins
    always_comb begin
        sync     = sync_q[SYNC_STAGES-1];
        accept   = (sync != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d    = (sync == stable_q || accept) ? '0 : cnt_q + CW'(1);
        stable_d = accept ? sync : stable_q;
        rise_d   = accept & sync;
        fall_d   = accept & ~sync;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end
    assign level = stable_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
endmodule

// File: rtl/board_input_conditioner.sv
// board_input_conditioner: per-bit debounce of buttons and switches plus a
// running count of accepted button presses.
module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int N_SW            = DEF_N_SW,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input logic                        clk,
    input logic                        rst_n,
    board_input_conditioner_if.slave   io
);
    logic [N_BTN-1:0] btn_level, btn_press, btn_release;
    logic [N_SW-1:0]  sw_level, sw_rise, sw_fall;
    press_cnt_t       press_cnt_q, press_cnt_d;
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
            .clk(clk), .rst_n(rst_n), .raw(io.btn_raw[i]),
            .level(btn_level[i]), .rise(btn_press[i]), .fall(btn_release[i])
        );
    end
    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
            .clk(clk), .rst_n(rst_n), .raw(io.sw_raw[i]),
            .level(sw_level[i]), .rise(sw_rise[i]), .fall(sw_fall[i])
        );
    end
    always_comb press_cnt_d = press_cnt_q + PRESS_CNT_W'($countones(btn_press));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) press_cnt_q <= '0;
        else        press_cnt_q <= press_cnt_d;
    end
    // rise and fall come from the same accept and never overlap
    assign io.sw_change   = sw_rise | sw_fall;
    assign io.sw_level    = sw_level;
    assign io.btn_level   = btn_level;
    assign io.btn_press   = btn_press;
    assign io.btn_release = btn_release;
    assign io.press_cnt   = press_cnt_q;
endmodule

// File: tb/tb_board_input_conditioner.sv
// tb_board_input_conditioner: directed plan plus random pin activity against a
// hold-window reference model of every channel.
module tb_board_input_conditioner;
    import board_io_pkg::*;
    localparam int NB_BTN = 5, NB_SW = 8, SS = 2, D = 4;
    localparam int NB = NB_BTN + NB_SW, L = SS + D;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0, checks = 0;

    board_input_conditioner_if #(.N_BTN(NB_BTN), .N_SW(NB_SW)) io ();
    board_input_conditioner_if #(.N_BTN(16), .N_SW(1)) wio ();
    board_input_conditioner #(.N_BTN(NB_BTN), .N_SW(NB_SW), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D))
        dut (.clk(clk), .rst_n(rst_n), .io(io));
    board_input_conditioner #(.N_BTN(16), .N_SW(1), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D))
        wdut (.clk(clk), .rst_n(rst_n), .io(wio));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a pin's accepted value flips once its synchronized copy has
    // differed from it on each of the last D compare cycles.
    logic [NB-1:0] hist [L];
    logic [NB-1:0] m_st, m_rise, m_fall;
    logic [15:0]   m_cnt;

    function automatic logic [NB-1:0] held_mask();
        logic [NB-1:0] h = '1;
        for (int j = 1; j <= D; j++) h &= hist[j] ^ m_st;
        return h;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) hist[i] <= '0;
            m_st <= '0; m_rise <= '0; m_fall <= '0; m_cnt <= '0;
        end else begin
            for (int i = 0; i < L - 1; i++) hist[i] <= hist[i+1];
            hist[L-1] <= {io.sw_raw, io.btn_raw};
            m_st   <= m_st ^ held_mask();
            m_rise <= held_mask() & ~m_st;
            m_fall <= held_mask() & m_st;
            m_cnt  <= m_cnt + 16'($countones(m_rise[NB_BTN-1:0]));
        end
    end

    always @(negedge clk) begin
        chk("btn_level", 32'(io.btn_level), 32'(m_st[NB_BTN-1:0]));
        chk("btn_press", 32'(io.btn_press), 32'(m_rise[NB_BTN-1:0]));
        chk("btn_release", 32'(io.btn_release), 32'(m_fall[NB_BTN-1:0]));
        chk("sw_level", 32'(io.sw_level), 32'(m_st[NB-1:NB_BTN]));
        chk("sw_change", 32'(io.sw_change), 32'(m_rise[NB-1:NB_BTN] | m_fall[NB-1:NB_BTN]));
        chk("press_cnt", 32'(io.press_cnt), 32'(m_cnt));
    end

    task automatic wpulse(input logic [15:0] v);
        wio.btn_raw = v;
        repeat (4) @(negedge clk);
        wio.btn_raw = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int b;
        io.btn_raw = '0; io.sw_raw = 8'h81; wio.btn_raw = '0; wio.sw_raw = '0;
        // reset with switches held
        repeat (4) @(posedge clk);
        #1;
        chk("rst_sw", 32'({io.sw_level, io.sw_change}), 0);
        chk("rst_btn", 32'({io.btn_level, io.btn_press, io.btn_release}), 0);
        chk("rst_cnt", 32'(io.press_cnt), 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("t1_pre", 32'(io.sw_level), 0);
        @(posedge clk);
        #1 chk("t1_level", 32'(io.sw_level), 32'h81);
        chk("t1_change", 32'(io.sw_change), 32'h81);
        @(posedge clk);
        #1 chk("t1_change_end", 32'(io.sw_change), 0);
        // clean button step
        @(negedge clk) io.btn_raw = 5'b00100;
        repeat (5) @(posedge clk);
        #1 chk("t2_pre", 32'(io.btn_press), 0);
        @(posedge clk);
        #1 chk("t2_press", 32'(io.btn_press), 32'b00100);
        chk("t2_level", 32'(io.btn_level), 32'b00100);
        @(posedge clk);
        #1 chk("t2_press_end", 32'(io.btn_press), 0);
        chk("t2_cnt", 32'(io.press_cnt), 1);
        chk("model_cnt1", 32'(m_cnt), 1);
        repeat (14) @(negedge clk);
        io.btn_raw = '0;
        repeat (5) @(posedge clk);
        #1 chk("t2_rel_pre", 32'(io.btn_release), 0);
        @(posedge clk);
        #1 chk("t2_release", 32'(io.btn_release), 32'b00100);
        chk("t2_level_low", 32'(io.btn_level), 0);
        @(posedge clk);
        #1 chk("t2_release_end", 32'(io.btn_release), 0);
        // bounce then settle
        for (int i = 0; i < 15; i++) begin
            @(negedge clk) io.btn_raw[0] = i[0];
            @(negedge clk) chk("t3_bounce", 32'(io.btn_press), 0);
        end
        @(negedge clk) io.btn_raw[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("t3_pre", 32'(io.btn_press), 0);
        @(posedge clk);
        #1 chk("t3_press", 32'(io.btn_press), 32'b00001);
        @(posedge clk);
        #1 chk("t3_cnt", 32'(io.press_cnt), 2);
        // three-cycle glitch is rejected
        @(negedge clk) io.sw_raw[5] = 1'b1;
        repeat (3) @(negedge clk);
        io.sw_raw[5] = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk) chk("t4_glitch", 32'({io.sw_level, io.sw_change}), 32'h8100);
        // exactly D cycles is accepted
        @(negedge clk) io.sw_raw[6] = 1'b1;
        repeat (4) @(negedge clk);
        io.sw_raw[6] = 1'b0;
        @(posedge clk);
        #1 chk("t4_hold_pre", 32'(io.sw_change), 0);
        @(posedge clk);
        #1 chk("t4_hold_change", 32'(io.sw_change), 32'h40);
        chk("t4_hold_level", 32'(io.sw_level), 32'hC1);
        repeat (4) @(posedge clk);
        #1 chk("t4_hold_fall", 32'(io.sw_change), 32'h40);
        chk("t4_hold_level_low", 32'(io.sw_level), 32'h81);
        // simultaneous presses from a clean reset
        @(negedge clk) begin io.btn_raw = '0; io.sw_raw = '0; end
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk) io.btn_raw = 5'h1F;
        repeat (5) @(posedge clk);
        #1 chk("t5_pre", 32'(io.btn_press), 0);
        @(posedge clk);
        #1 chk("t5_press", 32'(io.btn_press), 32'h1F);
        chk("t5_level", 32'(io.btn_level), 32'h1F);
        @(posedge clk);
        #1 chk("t5_cnt", 32'(io.press_cnt), 5);
        chk("model_cnt5", 32'(m_cnt), 5);
        @(negedge clk) io.btn_raw = '0;
        repeat (8) @(negedge clk);
        // press counter wrap on the wide instance
        for (int i = 0; i < 4095; i++) wpulse(16'hFFFF);
        chk("t6_bulk", 32'(wio.press_cnt), 32'hFFF0);
        wpulse(16'h3FFF);
        chk("t6_preload", 32'(wio.press_cnt), 32'hFFFE);
        wpulse(16'h0007);
        chk("t6_wrap", 32'(wio.press_cnt), 32'h0001);
        // reset in the middle of a qualification
        io.btn_raw[1] = 1'b1;
        repeat (4) @(posedge clk);
        #1 begin rst_n = 1'b0; io.btn_raw = '0; end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk) chk("t7_nopulse", 32'({io.btn_press, io.btn_level}), 0);
            chk("t7_cnt", 32'(io.press_cnt), 0);
        end
        // random pin activity with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                b = int'($urandom_range(0, NB - 1));
                if (b < NB_BTN) io.btn_raw[b] = ~io.btn_raw[b];
                else io.sw_raw[b-NB_BTN] = ~io.sw_raw[b-NB_BTN];
            end
            if ($urandom_range(0, 999) == 0) begin
                @(posedge clk);
                #1 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
